// File: rtl/z88_bus_master.sv
// Z80-style bus master driving the Blink gate array: sequences T1/T2/TW/T3 machine cycles
// for memory and IO transactions, with automatic IO wait states and a wait_n timeout abort.
module z88_bus_master #(
    parameter int unsigned IO_WAIT  = 1,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        mck,
    input  logic        rin,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_io,
    input  logic        req_wr,
    input  logic        req_m1,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,

    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,

    output logic [15:0] ca,
    output logic [7:0]  bus_do,
    output logic        bus_oe,
    input  logic [7:0]  bus_di,
    output logic        mrq_n,
    output logic        ior_n,
    output logic        crd_n,
    output logic        cm1_n,
    input  logic        wait_n
);

    localparam logic [1:0] IoWaitCnt  = 2'(IO_WAIT);
    localparam logic [8:0] WaitMaxCnt = 9'(WAIT_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StTw,
        StT3
    } state_e;

    state_e      state_q, state_d;

    logic        io_q, io_d;
    logic        wr_q, wr_d;
    logic        m1_q, m1_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic [1:0]  auto_q, auto_d;
    logic [7:0]  tmo_q, tmo_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        tmo_hit;

    // Timeout fires on the TW edge whose low wait_n brings the count up to WAIT_MAX.
    assign tmo_hit = ({1'b0, tmo_q} + 9'd1) >= WaitMaxCnt;

    always_comb begin
        state_d     = state_q;
        io_d        = io_q;
        wr_d        = wr_q;
        m1_d        = m1_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        auto_d      = auto_q;
        tmo_d       = tmo_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rdata_d     = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    io_d    = req_io;
                    wr_d    = req_wr;
                    m1_d    = req_m1;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = StT1;
                end
            end
            StT1: begin
                auto_d  = io_q ? IoWaitCnt : 2'd0;
                tmo_d   = 8'd0;
                state_d = StT2;
            end
            StT2: begin
                if ((auto_q != 2'd0) || !wait_n) begin
                    state_d = StTw;
                end else begin
                    state_d = StT3;
                end
            end
            StTw: begin
                // Every TW consumes one automatic wait, whether or not wait_n is also held.
                auto_d = (auto_q != 2'd0) ? auto_q - 2'd1 : 2'd0;
                if (!wait_n) begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_hit) begin
                        state_d     = StIdle;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rdata_d     = 8'hFF;
                        tmo_d       = 8'd0;
                    end
                end else begin
                    tmo_d = 8'd0;
                    if (auto_q <= 2'd1) begin
                        state_d = StT3;
                    end
                end
            end
            StT3: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                if (!wr_q) begin
                    rdata_d = bus_di;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            state_q     <= StIdle;
            io_q        <= 1'b0;
            wr_q        <= 1'b0;
            m1_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            auto_q      <= 2'd0;
            tmo_q       <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            io_q        <= io_d;
            wr_q        <= wr_d;
            m1_q        <= m1_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            auto_q      <= auto_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
        end
    end

    logic active;
    logic io_strobe_phase;
    logic m1_phase;

    // Bus outputs decode straight from state so an asynchronous reset releases them at once.
    always_comb begin
        active          = (state_q != StIdle);
        io_strobe_phase = (state_q == StT2) || (state_q == StTw) || (state_q == StT3);
        m1_phase        = (state_q == StT1) || (state_q == StT2);

        req_ready = (state_q == StIdle);
        ca        = active ? addr_q : 16'h0000;
        mrq_n     = !(active && !io_q);
        ior_n     = !(io_q && io_strobe_phase);
        crd_n     = !(active && !wr_q);
        cm1_n     = !(m1_phase && !io_q && !wr_q && m1_q);
        bus_oe    = active && wr_q;
        bus_do    = (active && wr_q) ? wdata_q : 8'h00;

        rsp_valid = rsp_valid_q;
        rsp_err   = rsp_err_q;
        rsp_rdata = rdata_q;
    end

endmodule

// File: tb/tb_z88_bus_master.sv
// Randomized self-checking bench for z88_bus_master; expected bus traces come from a
// per-transaction phase plan built from the machine-cycle timing rules.
module tb_z88_bus_master;

    localparam int unsigned IoWait  = 1;
    localparam int unsigned WaitMax = 4;

    localparam int PhIdle = 0;
    localparam int PhT1   = 1;
    localparam int PhT2   = 2;
    localparam int PhTw   = 3;
    localparam int PhT3   = 4;

    logic        mck = 1'b0;
    logic        rin;
    logic        req_valid;
    logic        req_ready;
    logic        req_io;
    logic        req_wr;
    logic        req_m1;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] ca;
    logic [7:0]  bus_do;
    logic        bus_oe;
    logic [7:0]  bus_di;
    logic        mrq_n;
    logic        ior_n;
    logic        crd_n;
    logic        cm1_n;
    logic        wait_n;

    int          n_checks = 0;
    int          n_errors = 0;

    logic        exp_rsp_valid;
    logic        exp_rsp_err;
    logic [7:0]  model_rdata;
    int          plan_q[$];
    bit          plan_abort;

    z88_bus_master #(
        .IO_WAIT  (IoWait),
        .WAIT_MAX (WaitMax)
    ) dut (
        .mck       (mck),
        .rin       (rin),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_io    (req_io),
        .req_wr    (req_wr),
        .req_m1    (req_m1),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ca        (ca),
        .bus_do    (bus_do),
        .bus_oe    (bus_oe),
        .bus_di    (bus_di),
        .mrq_n     (mrq_n),
        .ior_n     (ior_n),
        .crd_n     (crd_n),
        .cm1_n     (cm1_n),
        .wait_n    (wait_n)
    );

    always #5 mck = ~mck;

    function automatic bit wbit(input logic [31:0] w, input int k);
        return (k < 32) ? w[k] : 1'b1;
    endfunction

    // Cycle k of the transaction (k = 0 is T1) sees wait_n = w[k].
    task automatic make_plan(input bit io, input logic [31:0] w);
        int need;
        int spent;
        int low;
        int k;
        plan_q.delete();
        plan_abort = 1'b0;
        plan_q.push_back(PhT1);
        plan_q.push_back(PhT2);
        need  = io ? int'(IoWait) : 0;
        k     = 2;
        spent = 0;
        low   = 0;
        if (need > 0 || !wbit(w, 1)) begin
            while (1'b1) begin
                plan_q.push_back(PhTw);
                spent++;
                low = wbit(w, k) ? 0 : low + 1;
                if (low >= int'(WaitMax)) begin
                    plan_abort = 1'b1;
                    break;
                end
                if (spent >= need && wbit(w, k)) break;
                k++;
            end
        end
        if (!plan_abort) plan_q.push_back(PhT3);
    endtask

    function automatic logic [30:0] exp_vec(input int ph, input bit io, input bit wr,
                                            input bit m1, input logic [15:0] addr,
                                            input logic [7:0] wdata, input bit rv);
        logic        mrq, ior, crd, cm1, oe, rdy, v;
        logic [7:0]  d;
        logic [15:0] a;
        if (ph == PhIdle) begin
            rdy = 1'b1; v = rv; mrq = 1'b1; ior = 1'b1; crd = 1'b1; cm1 = 1'b1;
            oe = 1'b0; d = 8'h00; a = 16'h0000;
        end else begin
            rdy = 1'b0;
            v   = 1'b0;
            mrq = io;
            ior = !(io && ph != PhT1);
            crd = wr;
            cm1 = !(!io && !wr && m1 && (ph == PhT1 || ph == PhT2));
            oe  = wr;
            d   = wr ? wdata : 8'h00;
            a   = addr;
        end
        return {rdy, v, mrq, ior, crd, cm1, oe, d, a};
    endfunction

    function automatic logic [30:0] obs_vec();
        return {req_ready, rsp_valid, mrq_n, ior_n, crd_n, cm1_n, bus_oe,
                bus_oe ? bus_do : 8'h00, ca};
    endfunction

    task automatic idle_cycle(input string name);
        logic [30:0] e;
        req_valid = 1'b0;
        req_io    = 1'($urandom);
        req_wr    = 1'($urandom);
        req_addr  = 16'($urandom);
        wait_n    = 1'($urandom);
        bus_di    = 8'($urandom);
        @(negedge mck);
        e = exp_vec(PhIdle, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, exp_rsp_valid);
        n_checks++;
        if (obs_vec() !== e) begin
            n_errors++;
            $display("FAIL %s idle: got %h expected %h", name, obs_vec(), e);
        end
        n_checks++;
        if (rsp_rdata !== model_rdata) begin
            n_errors++;
            $display("FAIL %s rdata: got %h expected %h", name, rsp_rdata, model_rdata);
        end
        if (exp_rsp_valid) begin
            n_checks++;
            if (rsp_err !== exp_rsp_err) begin
                n_errors++;
                $display("FAIL %s err: got %b expected %b", name, rsp_err, exp_rsp_err);
            end
        end
        @(posedge mck);
        #1;
        exp_rsp_valid = 1'b0;
    endtask

    // Presents the request in the current IDLE cycle (checking any pending response there),
    // then checks every bus phase; rst_at >= 0 pulses rin asynchronously in that cycle.
    task automatic run_txn(input bit io, input bit wr, input bit m1, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rdata,
                           input logic [31:0] w, input int rst_at, input string name);
        logic [30:0] e;
        make_plan(io, w);
        req_valid = 1'b1;
        req_io    = io;
        req_wr    = wr;
        req_m1    = m1;
        req_addr  = addr;
        req_wdata = wdata;
        wait_n    = 1'b1;
        bus_di    = 8'($urandom);
        @(negedge mck);
        e = exp_vec(PhIdle, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, exp_rsp_valid);
        n_checks++;
        if (obs_vec() !== e) begin
            n_errors++;
            $display("FAIL %s accept: got %h expected %h", name, obs_vec(), e);
        end
        n_checks++;
        if (rsp_rdata !== model_rdata) begin
            n_errors++;
            $display("FAIL %s prev rdata: got %h expected %h", name, rsp_rdata, model_rdata);
        end
        if (exp_rsp_valid) begin
            n_checks++;
            if (rsp_err !== exp_rsp_err) begin
                n_errors++;
                $display("FAIL %s prev err: got %b expected %b", name, rsp_err, exp_rsp_err);
            end
        end
        @(posedge mck);
        #1;
        for (int k = 0; k < plan_q.size(); k++) begin
            // Request lines are don't-care outside IDLE; scramble them.
            req_valid = 1'($urandom);
            req_io    = 1'($urandom);
            req_wr    = 1'($urandom);
            req_m1    = 1'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 8'($urandom);
            wait_n    = wbit(w, k);
            bus_di    = (plan_q[k] == PhT3) ? rdata : 8'($urandom);
            if (k == rst_at) begin
                #1 rin = 1'b1;
                #1;
                e = exp_vec(PhIdle, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0);
                n_checks++;
                if (obs_vec() !== e) begin
                    n_errors++;
                    $display("FAIL %s async reset: got %h expected %h", name, obs_vec(), e);
                end
                n_checks++;
                if (rsp_rdata !== 8'h00) begin
                    n_errors++;
                    $display("FAIL %s reset rdata: got %h expected 00", name, rsp_rdata);
                end
                rin       = 1'b0;
                req_valid = 1'b0;
                @(posedge mck);
                #1;
                exp_rsp_valid = 1'b0;
                model_rdata   = 8'h00;
                return;
            end
            @(negedge mck);
            e = exp_vec(plan_q[k], io, wr, m1, addr, wdata, 1'b0);
            n_checks++;
            if (obs_vec() !== e) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, obs_vec(), e);
            end
            @(posedge mck);
            #1;
        end
        req_valid     = 1'b0;
        exp_rsp_valid = 1'b1;
        exp_rsp_err   = plan_abort;
        if (plan_abort) model_rdata = 8'hFF;
        else if (!wr) model_rdata = rdata;
    endtask

    task automatic test_reset();
        rin = 1'b1;
        #1;
        n_checks++;
        if (obs_vec() !== exp_vec(PhIdle, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0)) begin
            n_errors++;
            $display("FAIL reset bus: got %h", obs_vec());
        end
        n_checks++;
        if ({rsp_err, rsp_rdata, bus_do} !== 17'h0) begin
            n_errors++;
            $display("FAIL reset regs: got %h expected 00000", {rsp_err, rsp_rdata, bus_do});
        end
        repeat (2) @(posedge mck);
        @(negedge mck);
        rin = 1'b0;
        @(posedge mck);
        #1;
        exp_rsp_valid = 1'b0;
        exp_rsp_err   = 1'b0;
        model_rdata   = 8'h00;
        idle_cycle("reset_idle");
    endtask

    task automatic test_mem_read();
        run_txn(1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'hA5, '1, -1, "mem_read");
        idle_cycle("mem_read_rsp");
    endtask

    task automatic test_io_write();
        run_txn(1'b1, 1'b1, 1'b0, 16'h05B0, 8'h04, 8'h5A, '1, -1, "io_write");
        idle_cycle("io_write_rsp");
    endtask

    task automatic test_opcode_fetch();
        run_txn(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h3E, '1, -1, "m1_read");
        idle_cycle("m1_read_rsp");
        run_txn(1'b0, 1'b1, 1'b1, 16'h0000, 8'h77, 8'h00, '1, -1, "m1_write");
        idle_cycle("m1_write_rsp");
    endtask

    task automatic test_mem_wait();
        run_txn(1'b0, 1'b0, 1'b0, 16'h8123, 8'h00, 8'hC3, 32'hFFFF_FFF1, -1, "mem_wait");
        idle_cycle("mem_wait_rsp");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b0, 1'b0, 16'h2000, 8'h00, 8'h11, 32'h0000_0001, -1, "timeout");
        idle_cycle("timeout_rsp");
        run_txn(1'b1, 1'b1, 1'b0, 16'h00B5, 8'h9C, 8'h00, 32'h0000_0001, -1, "io_timeout");
        idle_cycle("io_timeout_rsp");
    endtask

    task automatic test_reset_mid();
        run_txn(1'b1, 1'b0, 1'b0, 16'h00D0, 8'h00, 8'h42, '1, 2, "reset_mid");
        idle_cycle("reset_mid_idle");
        run_txn(1'b1, 1'b0, 1'b0, 16'h00D1, 8'h00, 8'h6B, '1, -1, "after_reset");
        idle_cycle("after_reset_rsp");
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 1'b1, 1'b0, 16'h1234, 8'hE7, 8'h00, '1, -1, "b2b_0");
        run_txn(1'b1, 1'b0, 1'b0, 16'h00FE, 8'h00, 8'h81, '1, -1, "b2b_1");
        run_txn(1'b0, 1'b0, 1'b1, 16'hC000, 8'h00, 8'h2D, '1, -1, "b2b_2");
        idle_cycle("b2b_rsp");
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) w = $urandom;
            else w = $urandom | $urandom | $urandom;
            run_txn(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
                    8'($urandom), w, -1, "random");
            if ($urandom_range(0, 1) == 0) idle_cycle("random_gap");
        end
        idle_cycle("random_end");
    endtask

    initial begin
        rin       = 1'b1;
        req_valid = 1'b0;
        req_io    = 1'b0;
        req_wr    = 1'b0;
        req_m1    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 8'h00;
        bus_di    = 8'h00;
        wait_n    = 1'b1;
        exp_rsp_valid = 1'b0;
        exp_rsp_err   = 1'b0;
        model_rdata   = 8'h00;

        test_reset();
        test_mem_read();
        test_io_write();
        test_opcode_fetch();
        test_mem_wait();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
